axi_pkt_decoder_p: RTL and testbench

Parametrised successor to the FIFO-to-AXI4 packet decoder. Pops framed command packets from a first-word-fall-through (FWFT) command FIFO and decodes write packets (header plus len+1 data beats) and read packets (header only). Drives AXI4 AW/W/AR channels with full valid/ready handshakes. Adds type validation, resynchronisation on bad headers, and error/packet counters; sits between the host-side write FIFO and the AXI4 master BFM.

---
 rtl/axi_pkt_decoder_p_if.sv | 55 +++++
 rtl/axi_pkt_decoder_p.sv | 200 ++++++++++++++++++++
 tb/tb_axi_pkt_decoder_p.sv | 320 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi_pkt_decoder_p_if.sv
// AXI4 write-address, write-data and read-address channels of the packet decoder.
// The master side is the decoder; the slave side is the downstream AXI4 master BFM.
interface axi_pkt_decoder_p_if #(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 8,
    parameter int DATA_W = 64,
    parameter int STRB_W = DATA_W / 8
);
    logic              awvalid;
    logic              awready;
    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [LEN_W-1:0]  awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;

    logic              wvalid;
    logic              wready;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;

    logic              arvalid;
    logic              arready;
    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [LEN_W-1:0]  arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;

    modport master (
        output awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
        input  awready,
        output wvalid, wdata, wstrb, wlast,
        input  wready,
        output arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
        input  arready
    );

    modport slave (
        input  awvalid, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot,
        output awready,
        input  wvalid, wdata, wstrb, wlast,
        output wready,
        input  arvalid, arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot,
        output arready
    );
endinterface

// File: rtl/axi_pkt_decoder_p.sv
// Packet decoder: pops framed command packets from an FWFT FIFO and issues
// AXI4 AW/W (write packets) or AR (read packets) transactions, one at a time.
//
// state | meaning
// ------+---------------------------------------------------------------
// HDR   | idle; pop and classify the head word (bad headers are dropped)
// AW    | write address presented, waiting for awready
// WD    | write data streamed straight from the FIFO head, len+1 beats
// AR    | read address presented, waiting for arready
module axi_pkt_decoder_p #(
    parameter int         FIFO_W   = 128,
    parameter int         DATA_W   = 64,
    parameter int         STRB_W   = DATA_W / 8,
    parameter int         ADDR_W   = 32,
    parameter int         ID_W     = 4,
    parameter int         LEN_W    = 8,
    parameter logic [7:0] SOP_BYTE = 8'hAA,
    parameter logic [7:0] TYPE_WR  = 8'h01,
    parameter logic [7:0] TYPE_RD  = 8'h02
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   fifo_empty,
    input  logic [FIFO_W-1:0]      fifo_rdata,
    output logic                   fifo_rd_en,
    axi_pkt_decoder_p_if.master    axi,
    output logic                   busy,
    output logic [7:0]             err_cnt,
    output logic [15:0]            wr_pkt_cnt,
    output logic [15:0]            rd_pkt_cnt
);
    typedef enum logic [1:0] {S_HDR, S_AW, S_WD, S_AR} state_t;

    // Header field positions, packed from bit 0 upward
    localparam int ID_LSB    = ADDR_W;
    localparam int LEN_LSB   = ID_LSB + ID_W;
    localparam int SIZE_LSB  = LEN_LSB + LEN_W;
    localparam int BURST_LSB = SIZE_LSB + 3;
    localparam int LOCK_LSB  = BURST_LSB + 2;
    localparam int CACHE_LSB = LOCK_LSB + 1;
    localparam int PROT_LSB  = CACHE_LSB + 4;

    localparam logic [LEN_W:0] BEAT_ONE = 1;

    state_t            state;
    logic [LEN_W:0]    beat_cnt;

    logic              aw_valid_q;
    logic [ID_W-1:0]   aw_id_q;
    logic [ADDR_W-1:0] aw_addr_q;
    logic [LEN_W-1:0]  aw_len_q;
    logic [2:0]        aw_size_q;
    logic [1:0]        aw_burst_q;
    logic              aw_lock_q;
    logic [3:0]        aw_cache_q;
    logic [2:0]        aw_prot_q;

    logic              ar_valid_q;
    logic [ID_W-1:0]   ar_id_q;
    logic [ADDR_W-1:0] ar_addr_q;
    logic [LEN_W-1:0]  ar_len_q;
    logic [2:0]        ar_size_q;
    logic [1:0]        ar_burst_q;
    logic              ar_lock_q;
    logic [3:0]        ar_cache_q;
    logic [2:0]        ar_prot_q;

    logic              hdr_sop;
    logic [7:0]        hdr_type;
    logic              wd_valid;
    logic              wd_hs;
    logic              wd_last;
    logic              unused_fifo_bits;

    assign hdr_sop  = (fifo_rdata[FIFO_W-1 -: 8] == SOP_BYTE);
    assign hdr_type = fifo_rdata[FIFO_W-9 -: 8];

    // Data beats pass straight through; FWFT keeps the head word stable until
    // popped, so wvalid cannot drop without a handshake.
    assign wd_valid = (state == S_WD) && !fifo_empty;
    assign wd_hs    = wd_valid && axi.wready;
    assign wd_last  = (state == S_WD) && (beat_cnt == {1'b0, aw_len_q});

    // Gated by rst_n so nothing is popped while reset is held.
    assign fifo_rd_en = rst_n && (((state == S_HDR) && !fifo_empty) || wd_hs);
    assign busy       = (state != S_HDR);

    // Only the low data/strobe bits and the header fields are meaningful.
    assign unused_fifo_bits = ^fifo_rdata;

    assign axi.awvalid = aw_valid_q;
    assign axi.awid    = aw_id_q;
    assign axi.awaddr  = aw_addr_q;
    assign axi.awlen   = aw_len_q;
    assign axi.awsize  = aw_size_q;
    assign axi.awburst = aw_burst_q;
    assign axi.awlock  = aw_lock_q;
    assign axi.awcache = aw_cache_q;
    assign axi.awprot  = aw_prot_q;

    assign axi.wvalid  = wd_valid;
    assign axi.wdata   = (state == S_WD) ? fifo_rdata[DATA_W-1:0] : '0;
    assign axi.wstrb   = (state == S_WD) ? fifo_rdata[DATA_W +: STRB_W] : '0;
    assign axi.wlast   = wd_last;

    assign axi.arvalid = ar_valid_q;
    assign axi.arid    = ar_id_q;
    assign axi.araddr  = ar_addr_q;
    assign axi.arlen   = ar_len_q;
    assign axi.arsize  = ar_size_q;
    assign axi.arburst = ar_burst_q;
    assign axi.arlock  = ar_lock_q;
    assign axi.arcache = ar_cache_q;
    assign axi.arprot  = ar_prot_q;

    // Packet sequencing, registered channel fields and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_HDR;
            beat_cnt   <= '0;
            aw_valid_q <= 1'b0;
            aw_id_q    <= '0;
            aw_addr_q  <= '0;
            aw_len_q   <= '0;
            aw_size_q  <= '0;
            aw_burst_q <= '0;
            aw_lock_q  <= 1'b0;
            aw_cache_q <= '0;
            aw_prot_q  <= '0;
            ar_valid_q <= 1'b0;
            ar_id_q    <= '0;
            ar_addr_q  <= '0;
            ar_len_q   <= '0;
            ar_size_q  <= '0;
            ar_burst_q <= '0;
            ar_lock_q  <= 1'b0;
            ar_cache_q <= '0;
            ar_prot_q  <= '0;
            err_cnt    <= '0;
            wr_pkt_cnt <= '0;
            rd_pkt_cnt <= '0;
        end else begin
            case (state)
                S_HDR: begin
                    if (!fifo_empty) begin
                        if (hdr_sop && (hdr_type == TYPE_WR)) begin
                            aw_addr_q  <= fifo_rdata[ADDR_W-1:0];
                            aw_id_q    <= fifo_rdata[ID_LSB +: ID_W];
                            aw_len_q   <= fifo_rdata[LEN_LSB +: LEN_W];
                            aw_size_q  <= fifo_rdata[SIZE_LSB +: 3];
                            aw_burst_q <= fifo_rdata[BURST_LSB +: 2];
                            aw_lock_q  <= fifo_rdata[LOCK_LSB];
                            aw_cache_q <= fifo_rdata[CACHE_LSB +: 4];
                            aw_prot_q  <= fifo_rdata[PROT_LSB +: 3];
                            aw_valid_q <= 1'b1;
                            state      <= S_AW;
                        end else if (hdr_sop && (hdr_type == TYPE_RD)) begin
                            ar_addr_q  <= fifo_rdata[ADDR_W-1:0];
                            ar_id_q    <= fifo_rdata[ID_LSB +: ID_W];
                            ar_len_q   <= fifo_rdata[LEN_LSB +: LEN_W];
                            ar_size_q  <= fifo_rdata[SIZE_LSB +: 3];
                            ar_burst_q <= fifo_rdata[BURST_LSB +: 2];
                            ar_lock_q  <= fifo_rdata[LOCK_LSB];
                            ar_cache_q <= fifo_rdata[CACHE_LSB +: 4];
                            ar_prot_q  <= fifo_rdata[PROT_LSB +: 3];
                            ar_valid_q <= 1'b1;
                            state      <= S_AR;
                        end else if (err_cnt != 8'hFF) begin
                            err_cnt <= err_cnt + 8'd1;
                        end
                    end
                end
                S_AW: begin
                    if (axi.awready) begin
                        aw_valid_q <= 1'b0;
                        beat_cnt   <= '0;
                        state      <= S_WD;
                    end
                end
                S_WD: begin
                    if (wd_hs) begin
                        beat_cnt <= beat_cnt + BEAT_ONE;
                        if (wd_last) begin
                            wr_pkt_cnt <= wr_pkt_cnt + 16'd1;
                            state      <= S_HDR;
                        end
                    end
                end
                S_AR: begin
                    if (axi.arready) begin
                        ar_valid_q <= 1'b0;
                        rd_pkt_cnt <= rd_pkt_cnt + 16'd1;
                        state      <= S_HDR;
                    end
                end
                default: state <= S_HDR;
            endcase
        end
    end
endmodule

// File: tb/tb_axi_pkt_decoder_p.sv
// Directed bench for axi_pkt_decoder_p with a queue-style FWFT FIFO model
// and monitors recording AXI handshakes.
module tb_axi_pkt_decoder_p;
    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         fifo_empty;
    logic [127:0] fifo_rdata;
    logic         fifo_rd_en;
    logic         busy;
    logic [7:0]   err_cnt;
    logic [15:0]  wr_pkt_cnt;
    logic [15:0]  rd_pkt_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    axi_pkt_decoder_p_if #(.ADDR_W(32), .ID_W(4), .LEN_W(8), .DATA_W(64), .STRB_W(8)) axi ();

    axi_pkt_decoder_p dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_rdata (fifo_rdata),
        .fifo_rd_en (fifo_rd_en),
        .axi        (axi),
        .busy       (busy),
        .err_cnt    (err_cnt),
        .wr_pkt_cnt (wr_pkt_cnt),
        .rd_pkt_cnt (rd_pkt_cnt)
    );

    always #5 clk = ~clk;

    // FWFT FIFO model
    logic [127:0] fmem [0:1023];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (rd_ptr == wr_ptr);
    assign fifo_rdata = fmem[rd_ptr[9:0]];

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            n_tests++;
            if (fifo_empty) begin
                n_fail++;
                $display("FAIL pop_on_empty: fifo_rd_en=1 with fifo_empty=1 at %0t", $time);
            end
            rd_ptr <= rd_ptr + 1;
        end
    end

    // Handshake monitors
    logic [63:0] mw_data[$];
    logic [7:0]  mw_strb[$];
    logic        mw_last[$];
    int          aw_hs = 0;
    int          ar_hs = 0;
    logic [31:0] last_awaddr, last_araddr;
    logic [3:0]  last_awid, last_arid;
    logic [7:0]  last_arlen;

    always @(posedge clk) begin
        if (rst_n) begin
            if (axi.wvalid && axi.wready) begin
                mw_data.push_back(axi.wdata);
                mw_strb.push_back(axi.wstrb);
                mw_last.push_back(axi.wlast);
            end
            if (axi.awvalid && axi.awready) begin
                aw_hs++;
                last_awaddr = axi.awaddr;
                last_awid   = axi.awid;
            end
            if (axi.arvalid && axi.arready) begin
                ar_hs++;
                last_araddr = axi.araddr;
                last_arid   = axi.arid;
                last_arlen  = axi.arlen;
            end
        end
    end

    // size=3, burst=INCR, lock=0, cache=3, prot=2 in every header
    function automatic logic [127:0] mk_hdr(input logic [7:0] sop, input logic [7:0] typ,
                                            input logic [31:0] addr, input logic [3:0] id,
                                            input logic [7:0] len);
        logic [127:0] w;
        w = '0;
        w[127:120] = sop;
        w[119:112] = typ;
        w[31:0]    = addr;
        w[35:32]   = id;
        w[43:36]   = len;
        w[46:44]   = 3'd3;
        w[48:47]   = 2'd1;
        w[49]      = 1'b0;
        w[53:50]   = 4'h3;
        w[56:54]   = 3'd2;
        return w;
    endfunction

    function automatic logic [127:0] mk_data(input logic [63:0] d, input logic [7:0] s);
        logic [127:0] w;
        w = '0;
        w[63:0]  = d;
        w[71:64] = s;
        return w;
    endfunction

    task automatic push(input logic [127:0] w);
        fmem[wr_ptr[9:0]] = w;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic test_reset;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        axi.arready = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++; if ({axi.awvalid, axi.wvalid, axi.arvalid, fifo_rd_en, busy} !== 5'b0) begin
            n_fail++; $display("FAIL reset_valids: got %b exp 00000", {axi.awvalid, axi.wvalid, axi.arvalid, fifo_rd_en, busy}); end
        n_tests++; if ({err_cnt, wr_pkt_cnt, rd_pkt_cnt} !== 40'h0) begin
            n_fail++; $display("FAIL reset_counters: got %h exp 0", {err_cnt, wr_pkt_cnt, rd_pkt_cnt}); end
        n_tests++; if ({axi.awaddr, axi.araddr, axi.awlen, axi.wdata, axi.wlast} !== 137'h0) begin
            n_fail++; $display("FAIL reset_fields: got %h exp 0", {axi.awaddr, axi.araddr, axi.awlen, axi.wdata, axi.wlast}); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write_burst;
        logic [63:0] d [4];
        logic [7:0]  s [4];
        d[0] = 64'hA0A0_0000_0000_0000; s[0] = 8'hFF;
        d[1] = 64'hA0A0_0000_0000_0001; s[1] = 8'h0F;
        d[2] = 64'hA0A0_0000_0000_0002; s[2] = 8'hF0;
        d[3] = 64'hA0A0_0000_0000_0003; s[3] = 8'h81;
        @(negedge clk);
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        push(mk_hdr(8'hAA, 8'h01, 32'h1000_0040, 4'd3, 8'd3));
        for (int i = 0; i < 4; i++) push(mk_data(d[i], s[i]));
        #1;
        n_tests++; if ({fifo_rd_en, axi.awvalid} !== 2'b10) begin
            n_fail++; $display("FAIL wr_hdr_pop: rd_en/awvalid got %b exp 10", {fifo_rd_en, axi.awvalid}); end
        @(negedge clk);
        n_tests++; if ({axi.awvalid, fifo_rd_en, busy} !== 3'b101) begin
            n_fail++; $display("FAIL wr_aw_valid: awvalid/rd_en/busy got %b exp 101", {axi.awvalid, fifo_rd_en, busy}); end
        n_tests++; if ({axi.awaddr, axi.awid, axi.awlen} !== {32'h1000_0040, 4'd3, 8'd3}) begin
            n_fail++; $display("FAIL wr_aw_fields: got %h exp %h", {axi.awaddr, axi.awid, axi.awlen}, {32'h1000_0040, 4'd3, 8'd3}); end
        n_tests++; if ({axi.awsize, axi.awburst, axi.awlock, axi.awcache, axi.awprot} !== {3'd3, 2'd1, 1'b0, 4'h3, 3'd2}) begin
            n_fail++; $display("FAIL wr_aw_attr: got %h exp %h", {axi.awsize, axi.awburst, axi.awlock, axi.awcache, axi.awprot}, {3'd3, 2'd1, 1'b0, 4'h3, 3'd2}); end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_tests++; if ({axi.wvalid, fifo_rd_en, axi.awvalid} !== 3'b110) begin
                n_fail++; $display("FAIL wr_beat%0d_ctl: wvalid/rd_en/awvalid got %b exp 110", i, {axi.wvalid, fifo_rd_en, axi.awvalid}); end
            n_tests++; if ({axi.wdata, axi.wstrb, axi.wlast} !== {d[i], s[i], (i == 3)}) begin
                n_fail++; $display("FAIL wr_beat%0d_data: got %h exp %h", i, {axi.wdata, axi.wstrb, axi.wlast}, {d[i], s[i], (i == 3)}); end
        end
        @(negedge clk);
        n_tests++; if ({wr_pkt_cnt, fifo_empty, axi.wvalid, busy} !== {16'd1, 3'b100}) begin
            n_fail++; $display("FAIL wr_done: cnt/empty/wvalid/busy got %h exp %h", {wr_pkt_cnt, fifo_empty, axi.wvalid, busy}, {16'd1, 3'b100}); end
    endtask

    task automatic test_read_stall;
        int w0;
        int a0;
        w0 = mw_data.size();
        a0 = ar_hs;
        axi.arready = 1'b0;
        push(mk_hdr(8'hAA, 8'h02, 32'h2000_0000, 4'd5, 8'd7));
        #1;
        n_tests++; if (fifo_rd_en !== 1'b1) begin
            n_fail++; $display("FAIL rd_hdr_pop: got %b exp 1", fifo_rd_en); end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            n_tests++; if ({axi.arvalid, axi.araddr, axi.arid, axi.arlen, axi.wvalid} !== {1'b1, 32'h2000_0000, 4'd5, 8'd7, 1'b0}) begin
                n_fail++; $display("FAIL rd_stall%0d: got %h exp %h", k, {axi.arvalid, axi.araddr, axi.arid, axi.arlen, axi.wvalid}, {1'b1, 32'h2000_0000, 4'd5, 8'd7, 1'b0}); end
        end
        axi.arready = 1'b1;
        @(negedge clk);
        n_tests++; if ({axi.arvalid, rd_pkt_cnt, busy} !== {1'b0, 16'd1, 1'b0}) begin
            n_fail++; $display("FAIL rd_done: arvalid/cnt/busy got %h exp %h", {axi.arvalid, rd_pkt_cnt, busy}, {1'b0, 16'd1, 1'b0}); end
        n_tests++; if ((ar_hs - a0) != 1 || mw_data.size() != w0) begin
            n_fail++; $display("FAIL rd_hs_count: ar=%0d w=%0d exp ar=1 w=0", ar_hs - a0, mw_data.size() - w0); end
    endtask

    task automatic test_resync;
        axi.arready = 1'b1;
        push({8'h55, 8'h02, 112'h1});
        push({8'h55, 8'h01, 112'h2});
        push({8'h55, 8'hAA, 112'h3});
        push(mk_hdr(8'hAA, 8'h02, 32'h3000_1000, 4'd9, 8'd0));
        repeat (8) @(negedge clk);
        n_tests++; if (err_cnt !== 8'd3) begin
            n_fail++; $display("FAIL resync_err: got %0d exp 3", err_cnt); end
        n_tests++; if ({rd_pkt_cnt, last_araddr, last_arid, fifo_empty} !== {16'd2, 32'h3000_1000, 4'd9, 1'b1}) begin
            n_fail++; $display("FAIL resync_read: got %h exp %h", {rd_pkt_cnt, last_araddr, last_arid, fifo_empty}, {16'd2, 32'h3000_1000, 4'd9, 1'b1}); end
    endtask

    task automatic test_sparse_write;
        int base;
        int guard;
        base = mw_data.size();
        axi.awready = 1'b1;
        axi.wready  = 1'b0;
        push(mk_hdr(8'hAA, 8'h01, 32'h4000_0000, 4'd1, 8'd1));
        push(mk_data(64'h1111_2222_3333_4444, 8'h3C));
        guard = 0;
        while (mw_data.size() < base + 1 && guard < 20) begin
            @(negedge clk);
            axi.wready = ~axi.wready;
            guard++;
        end
        n_tests++; if (mw_data.size() != base + 1) begin
            n_fail++; $display("FAIL sparse_beat0_timeout: got %0d beats exp 1", mw_data.size() - base); end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            axi.wready = ~axi.wready;
            n_tests++; if ({axi.wvalid, fifo_empty, busy} !== 3'b011) begin
                n_fail++; $display("FAIL sparse_empty%0d: wvalid/empty/busy got %b exp 011", k, {axi.wvalid, fifo_empty, busy}); end
        end
        push(mk_data(64'h5555_6666_7777_8888, 8'hC3));
        guard = 0;
        while (mw_data.size() < base + 2 && guard < 20) begin
            @(negedge clk);
            axi.wready = ~axi.wready;
            guard++;
        end
        repeat (2) @(negedge clk);
        n_tests++; if (mw_data.size() != base + 2) begin
            n_fail++; $display("FAIL sparse_hs_count: got %0d exp 2", mw_data.size() - base); end
        else begin
            n_tests++; if ({mw_data[base], mw_strb[base], mw_last[base]} !== {64'h1111_2222_3333_4444, 8'h3C, 1'b0}) begin
                n_fail++; $display("FAIL sparse_beat0: got %h", {mw_data[base], mw_strb[base], mw_last[base]}); end
            n_tests++; if ({mw_data[base+1], mw_strb[base+1], mw_last[base+1]} !== {64'h5555_6666_7777_8888, 8'hC3, 1'b1}) begin
                n_fail++; $display("FAIL sparse_beat1: got %h", {mw_data[base+1], mw_strb[base+1], mw_last[base+1]}); end
        end
        n_tests++; if ({wr_pkt_cnt, busy} !== {16'd2, 1'b0}) begin
            n_fail++; $display("FAIL sparse_done: got %h exp %h", {wr_pkt_cnt, busy}, {16'd2, 1'b0}); end
    endtask

    task automatic test_reset_mid_burst;
        int base;
        base = mw_data.size();
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        push(mk_hdr(8'hAA, 8'h01, 32'h5000_0000, 4'd2, 8'd3));
        for (int i = 0; i < 4; i++) push(mk_data(64'h0BAD_0000_0000_0000 + 64'(i), 8'hFF));
        repeat (4) @(negedge clk);
        n_tests++; if (mw_data.size() != base + 2 || axi.wvalid !== 1'b1) begin
            n_fail++; $display("FAIL rst_pre: beats=%0d wvalid=%b exp 2/1", mw_data.size() - base, axi.wvalid); end
        rst_n = 1'b0;
        #1;
        n_tests++; if ({axi.awvalid, axi.wvalid, axi.wlast, axi.arvalid, fifo_rd_en, busy} !== 6'b0) begin
            n_fail++; $display("FAIL rst_async_ctl: got %b exp 000000", {axi.awvalid, axi.wvalid, axi.wlast, axi.arvalid, fifo_rd_en, busy}); end
        n_tests++; if ({err_cnt, wr_pkt_cnt, rd_pkt_cnt, axi.awaddr, axi.awlen, axi.wdata} !== 144'h0) begin
            n_fail++; $display("FAIL rst_async_regs: got %h exp 0", {err_cnt, wr_pkt_cnt, rd_pkt_cnt, axi.awaddr, axi.awlen, axi.wdata}); end
        @(negedge clk);
        n_tests++; if (fifo_rd_en !== 1'b0 || fifo_empty !== 1'b0) begin
            n_fail++; $display("FAIL rst_hold: rd_en=%b empty=%b exp 0/0", fifo_rd_en, fifo_empty); end
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        n_tests++; if ({err_cnt, fifo_empty} !== {8'd2, 1'b1}) begin
            n_fail++; $display("FAIL rst_leftover_err: got %h exp %h", {err_cnt, fifo_empty}, {8'd2, 1'b1}); end
        push(mk_hdr(8'hAA, 8'h01, 32'h6000_0000, 4'd4, 8'd0));
        push(mk_data(64'hDEAD_BEEF_0123_4567, 8'hFF));
        repeat (6) @(negedge clk);
        n_tests++; if ({wr_pkt_cnt, last_awaddr, mw_data[$], mw_last[$]} !== {16'd1, 32'h6000_0000, 64'hDEAD_BEEF_0123_4567, 1'b1}) begin
            n_fail++; $display("FAIL rst_next_write: got %h", {wr_pkt_cnt, last_awaddr, mw_data[$], mw_last[$]}); end
    endtask

    task automatic test_saturate_back_to_back;
        for (int i = 0; i < 300; i++) push({8'h55, 120'(i)});
        repeat (305) @(negedge clk);
        n_tests++; if ({err_cnt, fifo_empty} !== {8'hFF, 1'b1}) begin
            n_fail++; $display("FAIL sat_err: got %h exp %h", {err_cnt, fifo_empty}, {8'hFF, 1'b1}); end
        axi.awready = 1'b1;
        axi.wready  = 1'b1;
        axi.arready = 1'b1;
        push(mk_hdr(8'hAA, 8'h01, 32'h7000_0000, 4'd6, 8'd0));
        push(mk_data(64'hCAFE_F00D_0000_1234, 8'h5A));
        push(mk_hdr(8'hAA, 8'h02, 32'h7100_0000, 4'd7, 8'd2));
        #1;
        n_tests++; if (fifo_rd_en !== 1'b1) begin
            n_fail++; $display("FAIL b2b_wr_pop: got %b exp 1", fifo_rd_en); end
        @(negedge clk);
        n_tests++; if (axi.awvalid !== 1'b1) begin
            n_fail++; $display("FAIL b2b_aw: got %b exp 1", axi.awvalid); end
        @(negedge clk);
        n_tests++; if ({axi.wvalid, axi.wlast, axi.wdata, axi.wstrb} !== {2'b11, 64'hCAFE_F00D_0000_1234, 8'h5A}) begin
            n_fail++; $display("FAIL b2b_w: got %h", {axi.wvalid, axi.wlast, axi.wdata, axi.wstrb}); end
        @(negedge clk);
        n_tests++; if ({axi.arvalid, fifo_rd_en, busy} !== 3'b010) begin
            n_fail++; $display("FAIL b2b_gap: arvalid/rd_en/busy got %b exp 010", {axi.arvalid, fifo_rd_en, busy}); end
        @(negedge clk);
        n_tests++; if ({axi.arvalid, axi.araddr, axi.arid, axi.arlen} !== {1'b1, 32'h7100_0000, 4'd7, 8'd2}) begin
            n_fail++; $display("FAIL b2b_ar: got %h", {axi.arvalid, axi.araddr, axi.arid, axi.arlen}); end
        @(negedge clk);
        n_tests++; if ({wr_pkt_cnt, rd_pkt_cnt, err_cnt, busy, fifo_empty} !== {16'd2, 16'd1, 8'hFF, 2'b01}) begin
            n_fail++; $display("FAIL b2b_done: got %h exp %h", {wr_pkt_cnt, rd_pkt_cnt, err_cnt, busy, fifo_empty}, {16'd2, 16'd1, 8'hFF, 2'b01}); end
    endtask

    initial begin
        test_reset;
        test_write_burst;
        test_read_stall;
        test_resync;
        test_sparse_write;
        test_reset_mid_burst;
        test_saturate_back_to_back;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
